// File: rtl/nios_display_sw_irq_ctrl.sv
// nios_display_sw_irq_ctrl
//   Avalon-MM slave for the board switches of the Nios display system.
//   Each switch is synchronised (2 flops) and optionally debounced. Any
//   change of the accepted level is latched into a write-1-to-clear edge
//   capture register. A maskable level interrupt is raised towards the
//   Nios II.
//
//   Build option: define SW_DEBOUNCE_EN to instantiate the per-bit debounce
//   counters. Without it the accepted level follows the synchronised input
//   one clock later.
//
// Ports
//   clk         system clock
//   reset_n     asynchronous active-low reset
//   address     Avalon word address (0 data, 1 raw, 2 irqmask, 3 edgecap)
//   chipselect  Avalon slave select
//   write_n     Avalon write strobe, active low
//   writedata   Avalon write data
//   readdata    Avalon read data, registered (1 clk latency, no side effects)
//   in_port     raw asynchronous switch levels
//   irq         level interrupt, active high
module nios_display_sw_irq_ctrl #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  logic [WIDTH-1:0] meta;
  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] stable;
  logic [WIDTH-1:0] stable_nxt;
  logic [WIDTH-1:0] edgecap;
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] w1c_clr;
  logic [31:0]      rd_mux;
  logic             wr_en;
  logic             unused_wdata;

  assign wr_en        = chipselect && !write_n;
  // Only the low WIDTH bits of writedata are meaningful.
  assign unused_wdata = ^writedata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      meta <= '0;
      sync <= '0;
    end else begin
      meta <= in_port;
      sync <= meta;
    end
  end

`ifdef SW_DEBOUNCE_EN
  logic [CNT_W-1:0] cnt     [WIDTH];
  logic [CNT_W-1:0] cnt_nxt [WIDTH];

  // A bit is accepted once it has differed from the stable level for
  // DEBOUNCE_CYCLES consecutive clocks. Any agreeing clock restarts the
  // count, so short glitches never reach the terminal value.
  always_comb begin
    stable_nxt = stable;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_nxt[i] = '0;
      if (sync[i] != stable[i]) begin
        if (cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          stable_nxt[i] = sync[i];
        end else begin
          cnt_nxt[i] = cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      cnt <= cnt_nxt;
    end
  end
`else
  // Debounce parameters have no effect in this build.
  localparam int unused_debounce_params = DEBOUNCE_CYCLES + CNT_W;

  assign stable_nxt = sync;
`endif

  assign w1c_clr = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

  always_comb begin
    rd_mux = '0;
    case (address)
      2'd0: rd_mux[WIDTH-1:0] = stable;
      2'd1: rd_mux[WIDTH-1:0] = sync;
      2'd2: rd_mux[WIDTH-1:0] = irqmask;
      2'd3: rd_mux[WIDTH-1:0] = edgecap;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stable   <= '0;
      edgecap  <= '0;
      irqmask  <= '0;
      readdata <= '0;
    end else begin
      stable   <= stable_nxt;
      // Set term is ORed after the clear so a new edge beats a W1C write.
      edgecap  <= (edgecap & ~w1c_clr) | (stable ^ stable_nxt);
      readdata <= rd_mux;
      if (wr_en && address == 2'd2) begin
        irqmask <= writedata[WIDTH-1:0];
      end
    end
  end

  assign irq = |(edgecap & irqmask);

endmodule
